ila_window_tracker: RTL and testbench

Parametrised verification sequencer for ILA-vs-implementation refinement checks. It tracks up to NCH concurrently issued instruction windows, each with its own cycle counter and start/ended/second-ended flags. At each window's end cycle it compares NVAR architectural state variables from the ILA model against refinement-mapped implementation values. It sits in the verification wrapper between the ILA instance and the pipeline under test, replacing single-shot fixed-latency bookkeeping with multi-channel, per-instruction-latency, recyclable tracking.

---
 rtl/ila_track_pkg.sv | 30 +++
 rtl/ila_track_chan.sv | 107 ++++++++++
 rtl/ila_window_tracker.sv | 133 +++++++++++++
 tb/tb_ila_window_tracker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ila_track_pkg.sv
// ila_track_pkg: shared types and helpers for the ILA window tracker.
//   chan_state_e : per-channel window state (IDLE, START, RUN, POST, DONE)
//   clamp_lat    : maps a requested end cycle into the legal range 1..max_cnt
package ila_track_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } chan_state_e;

  // A latency of 0 would never be reached from START (cnt is already past 0
  // in RUN), and one above max_cnt would never be reached by a saturating
  // counter, so both are pulled into range to guarantee every window ends.
  function automatic int unsigned clamp_lat(input int unsigned lat,
                                            input int unsigned max_cnt);
    int unsigned res;
    if (lat == 32'd0) begin
      res = 32'd1;
    end else if (lat > max_cnt) begin
      res = max_cnt;
    end else begin
      res = lat;
    end
    return res;
  endfunction

endpackage

// File: rtl/ila_track_chan.sv
// ila_track_chan: one instruction-window channel.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : channel granted this cycle (only acted on while IDLE)
//   lat_in      : already-clamped end cycle, latched on start
//   state       : current window state
//   cnt         : cycle counter, 0 in START, saturating at MAX_CNT
//   end_pulse   : single-cycle pulse in RUN when cnt == latched latency
//   end2_pulse  : single-cycle pulse GAP cycles after end_pulse
module ila_track_chan
  import ila_track_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int MAX_CNT = 6,
  parameter int GAP     = 1,
  parameter int RECYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] lat_in,
  output chan_state_e      state,
  output logic [CNT_W-1:0] cnt,
  output logic             end_pulse,
  output logic             end2_pulse
);

  localparam int PW = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CNT);
  localparam logic [PW-1:0]    POST_LOAD = PW'(GAP);
  localparam logic [PW-1:0]    POST_ONE  = PW'(1);

  chan_state_e      state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [CNT_W-1:0] lat_r, lat_nxt_s;
  logic [PW-1:0]    post_r, post_nxt_s;

  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_W'(1));

  // Next-state logic for the window FSM, counter, latency and post counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    lat_nxt_s   = lat_r;
    post_nxt_s  = post_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = START;
          cnt_nxt_s   = '0;
          lat_nxt_s   = lat_in;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = cnt_inc_s;
      end
      RUN: begin
        cnt_nxt_s = cnt_inc_s;
        if (cnt_r == lat_r) begin
          state_nxt_s = POST;
          post_nxt_s  = POST_LOAD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      POST: begin
        cnt_nxt_s = cnt_inc_s;
        if (post_r == POST_ONE) begin
          state_nxt_s = (RECYCLE != 0) ? IDLE : DONE;
          post_nxt_s  = '0;
        end else begin
          post_nxt_s = post_r - POST_ONE;
        end
      end
      DONE: begin
        state_nxt_s = DONE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Channel state registers; reset aborts any window in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      lat_r   <= '0;
      post_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      lat_r   <= lat_nxt_s;
      post_r  <= post_nxt_s;
    end
  end

  assign state      = state_r;
  assign cnt        = cnt_r;
  assign end_pulse  = (state_r == RUN) && (cnt_r == lat_r);
  assign end2_pulse = (state_r == POST) && (post_r == POST_ONE);

endmodule

// File: rtl/ila_window_tracker.sv
// ila_window_tracker: multi-channel ILA-vs-implementation refinement sequencer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   issue_valid   : request to open a window; issue_ready: a channel can take it
//   issue_lat     : window end cycle counted from START; issue_ch: granted channel
//   ila_state     : ILA variables, var i at [i*VAR_W +: VAR_W]
//   impl_state    : refinement-mapped implementation values, same packing
//   var_mask      : 1 = variable takes part in the compare
//   ch_busy       : channel in START/RUN/POST; cycle_cnt: per-channel counters
//   end_pulse     : channel at its end cycle; end2_pulse: at its second end
//   match_ok      : some channel ended this cycle and all masked vars agree
//   mismatch      : sticky per-variable mismatch flags (cleared only by rst)
//   reseted       : sticky, set once rst has been seen
module ila_window_tracker
  import ila_track_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int CNT_W   = 4,
  parameter int MAX_CNT = 6,
  parameter int NVAR    = 4,
  parameter int VAR_W   = 8,
  parameter int GAP     = 1,
  parameter int RECYCLE = 1,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [CNT_W-1:0]       issue_lat,
  output logic [CH_W-1:0]        issue_ch,
  input  logic [NVAR*VAR_W-1:0]  ila_state,
  input  logic [NVAR*VAR_W-1:0]  impl_state,
  input  logic [NVAR-1:0]        var_mask,
  output logic [NCH-1:0]         ch_busy,
  output logic [NCH*CNT_W-1:0]   cycle_cnt,
  output logic [NCH-1:0]         end_pulse,
  output logic [NCH-1:0]         end2_pulse,
  output logic                   match_ok,
  output logic [NVAR-1:0]        mismatch
,
  output logic                   reseted
);

  chan_state_e      ch_state_s [NCH];
  logic [NCH-1:0]   start_s;
  logic             grant_found_s;
  logic [CH_W-1:0]  grant_idx_s;
  logic [CNT_W-1:0] lat_clamped_s;
  logic [NVAR-1:0]  eq_s;
  logic             any_end_s;
  logic [NVAR-1:0]  mismatch_r;
  // Power-up value: the wrapper must see rst before it may issue windows.
  logic             reseted_r = 1'b0;

  assign lat_clamped_s = CNT_W'(clamp_lat(32'(issue_lat), 32'(MAX_CNT)));

  // Lowest-index IDLE channel wins the grant; a channel leaving POST only
  // shows IDLE from the next cycle, so it is never re-granted the same cycle.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!grant_found_s && (ch_state_s[c] == IDLE)) begin
        grant_found_s = 1'b1;
        grant_idx_s   = CH_W'(c);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  assign issue_ready = reseted_r && grant_found_s;
  assign issue_ch    = grant_idx_s;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    assign start_s[g] = issue_valid && issue_ready && (grant_idx_s == CH_W'(g));
    assign ch_busy[g] = (ch_state_s[g] != IDLE) && (ch_state_s[g] != DONE);

    ila_track_chan #(
      .CNT_W   (CNT_W),
      .MAX_CNT (MAX_CNT),
      .GAP     (GAP),
      .RECYCLE (RECYCLE)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .start      (start_s[g]),
      .lat_in     (lat_clamped_s),
      .state      (ch_state_s[g]),
      .cnt        (cycle_cnt[g*CNT_W +: CNT_W]),
      .end_pulse  (end_pulse[g]),
      .end2_pulse (end2_pulse[g])
    );
  end

  // Per-variable equality; masked-off variables always count as equal.
  always_comb begin
    eq_s = '0;
    for (int i = 0; i < NVAR; i++) begin
      eq_s[i] = (ila_state[i*VAR_W +: VAR_W] == impl_state[i*VAR_W +: VAR_W])
                || !var_mask[i];
    end
  end

  // Several channels ending together share this single compare.
  assign any_end_s = |end_pulse;
  assign match_ok  = any_end_s && (&eq_s);

  // Sticky mismatch flags, accumulated at every end cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_r <= '0;
    end else if (any_end_s) begin
      mismatch_r <= mismatch_r | ~eq_s;
    end else begin
      mismatch_r <= mismatch_r;
    end
  end

  // Sticky reset-seen flag; nothing ever clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      reseted_r <= 1'b1;
    end else begin
      reseted_r <= reseted_r;
    end
  end

  assign mismatch = mismatch_r;
  assign reseted  = reseted_r;

endmodule

// File: tb/tb_ila_window_tracker.sv
module tb_ila_window_tracker;

  localparam int NCH     = 2;
  localparam int CNT_W   = 4;
  localparam int MAX_CNT = 6;
  localparam int NVAR    = 4;
  localparam int VAR_W   = 8;
  localparam int GAP     = 1;
  localparam int CH_W    = 1;
  localparam int SW      = NVAR * VAR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [CNT_W-1:0]     issue_lat;
  logic [CH_W-1:0]      issue_ch;
  logic [SW-1:0]        ila_state;
  logic [SW-1:0]        impl_state;
  logic [NVAR-1:0]      var_mask;
  logic [NCH-1:0]       ch_busy;
  logic [NCH*CNT_W-1:0] cycle_cnt;
  logic [NCH-1:0]       end_pulse;
  logic [NCH-1:0]       end2_pulse;
  logic                 match_ok;
  logic [NVAR-1:0]      mismatch;
  logic                 reseted;

  ila_window_tracker #(
    .NCH(NCH), .CNT_W(CNT_W), .MAX_CNT(MAX_CNT), .NVAR(NVAR),
    .VAR_W(VAR_W), .GAP(GAP), .RECYCLE(1)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_lat(issue_lat), .issue_ch(issue_ch), .ila_state(ila_state),
    .impl_state(impl_state), .var_mask(var_mask), .ch_busy(ch_busy),
    .cycle_cnt(cycle_cnt), .end_pulse(end_pulse), .end2_pulse(end2_pulse),
    .match_ok(match_ok), .mismatch(mismatch), .reseted(reseted)
  );

  // Per-cycle expectations, pushed by the stimulus, popped by the monitor.
  typedef struct {
    int              cyc;
    logic            chk;
    logic            ready;
    logic            grant;
    int              ch;
    logic            match;
    logic [NVAR-1:0] mm;
    logic [NCH-1:0]  busy;
  } rec_t;

  // Expected pulse events of accepted windows.
  typedef struct {
    int   cyc;
    int   ch;
    logic second;
    int   cnt;
  } ev_t;

  rec_t rec_q[$];
  ev_t  ev_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: windows as time intervals in absolute cycle numbers.
  int              free_at  [NCH];
  int              start_at [NCH];
  int              end_at   [NCH];
  int              end2_at  [NCH];
  logic            m_reseted;
  logic [NVAR-1:0] m_mm;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      free_at[c]  = 0;
      start_at[c] = 0;
      end_at[c]   = -1;
      end2_at[c]  = -1;
    end
  endtask

  task automatic step(input logic v, input int lat, input logic r,
                      input logic [SW-1:0] ila, input logic [SW-1:0] impl,
                      input logic [NVAR-1:0] mask);
    rec_t            rec;
    ev_t             ev;
    int              now, g, lc;
    logic            found, any_end;
    logic [NVAR-1:0] neq;
    @(posedge clk);
    #1;
    rst         = r;
    issue_valid = v && !r;
    issue_lat   = CNT_W'(lat);
    ila_state   = ila;
    impl_state  = impl;
    var_mask    = mask;
    now         = cyc;

    rec.cyc = now;
    rec.chk = m_reseted;
    found = 1'b0;
    g = 0;
    for (int c = 0; c < NCH; c++) begin
      if (!found && free_at[c] <= now) begin
        found = 1'b1;
        g = c;
      end
    end
    rec.ready = m_reseted && found;
    rec.grant = issue_valid && rec.ready;
    rec.ch    = g;
    for (int c = 0; c < NCH; c++)
      rec.busy[c] = (now >= start_at[c]) && (now <= end2_at[c]);

    any_end = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (end_at[c] == now) any_end = 1'b1;
    neq = '0;
    for (int i = 0; i < NVAR; i++)
      neq[i] = (ila[i*VAR_W +: VAR_W] != impl[i*VAR_W +: VAR_W]) && mask[i];
    rec.match = any_end && (neq == '0);
    rec.mm    = m_mm;
    if (any_end) m_mm = m_mm | neq;

    if (rec.grant) begin
      lc = (lat == 0) ? 1 : ((lat > MAX_CNT) ? MAX_CNT : lat);
      start_at[g] = now + 1;
      end_at[g]   = now + 1 + lc;
      end2_at[g]  = end_at[g] + GAP;
      free_at[g]  = end2_at[g] + 1;
      ev.ch = g;
      ev.cyc = end_at[g];  ev.second = 1'b0; ev.cnt = lc;
      ev_q.push_back(ev);
      ev.cyc = end2_at[g]; ev.second = 1'b1;
      ev.cnt = (lc + GAP > MAX_CNT) ? MAX_CNT : lc + GAP;
      ev_q.push_back(ev);
    end
    rec_q.push_back(rec);

    if (r) begin
      m_reseted = 1'b1;
      m_mm = '0;
      model_clear();
      for (int i = ev_q.size() - 1; i >= 0; i--)
        if (ev_q[i].cyc > now) ev_q.delete(i);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin
    rec_t           rec;
    logic [NCH-1:0] exp_end, exp_end2;
    int             exp_c1 [NCH];
    int             exp_c2 [NCH];
    forever begin
      @(negedge clk);
      if (rec_q.size() != 0) begin
        rec = rec_q.pop_front();
        chk("issue_ready", 64'(issue_ready), 64'(rec.ready));
        if (rec.chk) begin
          if (rec.grant) chk("issue_ch", 64'(issue_ch), 64'(rec.ch));
          chk("match_ok", 64'(match_ok), 64'(rec.match));
          chk("mismatch", 64'(mismatch), 64'(rec.mm));
          chk("ch_busy", 64'(ch_busy), 64'(rec.busy));
          chk("reseted", 64'(reseted), 64'd1);
          exp_end  = '0;
          exp_end2 = '0;
          for (int c = 0; c < NCH; c++) begin
            exp_c1[c] = 0;
            exp_c2[c] = 0;
          end
          for (int i = ev_q.size() - 1; i >= 0; i--) begin
            if (ev_q[i].cyc == rec.cyc) begin
              if (ev_q[i].second) begin
                exp_end2[ev_q[i].ch] = 1'b1;
                exp_c2[ev_q[i].ch]   = ev_q[i].cnt;
              end else begin
                exp_end[ev_q[i].ch] = 1'b1;
                exp_c1[ev_q[i].ch]  = ev_q[i].cnt;
              end
              ev_q.delete(i);
            end
          end
          chk("end_pulse", 64'(end_pulse), 64'(exp_end));
          chk("end2_pulse", 64'(end2_pulse), 64'(exp_end2));
          for (int c = 0; c < NCH; c++) begin
            if (exp_end[c] && end_pulse[c])
              chk("cnt_at_end", 64'(cycle_cnt[c*CNT_W +: CNT_W]), 64'(exp_c1[c]));
            if (exp_end2[c] && end2_pulse[c])
              chk("cnt_at_end2", 64'(cycle_cnt[c*CNT_W +: CNT_W]), 64'(exp_c2[c]));
          end
        end
      end
    end
  end

  localparam logic [SW-1:0] EQ_S = 32'h1122_3344;
  localparam logic [SW-1:0] A_S  = 32'h115A_3344;
  localparam logic [SW-1:0] B_S  = 32'h115B_3344;

  initial begin
    logic [SW-1:0]   ila_v, impl_v;
    logic [NVAR-1:0] mask_v;
    rst         = 1'b0;
    issue_valid = 1'b0;
    issue_lat   = '0;
    ila_state   = '0;
    impl_state  = '0;
    var_mask    = '0;
    m_reseted   = 1'b0;
    m_mm        = '0;
    model_clear();

    // Requests before any reset must not be accepted.
    repeat (3) step(1'b1, 1, 1'b0, EQ_S, EQ_S, 4'hF);
    repeat (2) step(1'b0, 0, 1'b1, EQ_S, EQ_S, 4'hF);

    // lat=1 window, var2 differs and is compared.
    step(1'b1, 1, 1'b0, A_S, B_S, 4'hF);
    repeat (4) step(1'b0, 0, 1'b0, A_S, B_S, 4'hF);
    // Same difference with var2 masked off.
    step(1'b1, 1, 1'b0, A_S, B_S, 4'hB);
    repeat (4) step(1'b0, 0, 1'b0, A_S, B_S, 4'hB);

    // Back-to-back issues, then a persistent third request.
    step(1'b1, 3, 1'b0, EQ_S, EQ_S, 4'hF);
    step(1'b1, 1, 1'b0, EQ_S, EQ_S, 4'hF);
    repeat (6) step(1'b1, 2, 1'b0, EQ_S, EQ_S, 4'hF);
    repeat (10) step(1'b0, 0, 1'b0, EQ_S, EQ_S, 4'hF);

    // Latency above MAX_CNT and latency 0.
    step(1'b1, 15, 1'b0, EQ_S, EQ_S, 4'hF);
    repeat (10) step(1'b0, 0, 1'b0, EQ_S, EQ_S, 4'hF);
    step(1'b1, 0, 1'b0, EQ_S, EQ_S, 4'hF);
    repeat (5) step(1'b0, 0, 1'b0, EQ_S, EQ_S, 4'hF);

    // Reset in the middle of a RUN window.
    step(1'b1, 6, 1'b0, A_S, B_S, 4'hF);
    repeat (3) step(1'b0, 0, 1'b0, A_S, B_S, 4'hF);
    step(1'b0, 0, 1'b1, A_S, B_S, 4'hF);
    repeat (8) step(1'b0, 0, 1'b0, A_S, B_S, 4'hF);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      ila_v  = $urandom;
      impl_v = ila_v;
      if ($urandom_range(0, 3) == 0) impl_v = impl_v ^ (32'd1 << $urandom_range(0, 31));
      mask_v = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) < 60), $urandom_range(0, 15),
           ($urandom_range(0, 299) == 0), ila_v, impl_v, mask_v);
    end

    repeat (15) step(1'b0, 0, 1'b0, EQ_S, EQ_S, 4'hF);
    @(negedge clk);
    #1;
    chk("pending_pulses", 64'(ev_q.size()), 64'd0);
    chk("pending_records", 64'(rec_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
